scan_decoder: RTL and testbench
===============================

# scan_decoder

Parametrised, registered N-to-2^N one-hot decoder that succeeds the 2-to-4 decoder. It has an enable and two modes. Direct mode decodes a select bus. Scan mode walks every output in turn, holding each for a programmable dwell time, with a start/busy/done handshake. It sits between control logic and one-hot consumers such as row/column strobes, mux selects and LED/keypad scanning.

## Interface
- SEL_W, 2, select width; output width is 2^SEL_W (2 gives a 2-to-4 decoder).
- DWELL_W, 8, width of the dwell count.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enable; when 0, `y` is 0 and scan progress is frozen.
- mode  in  1  0 = direct decode, 1 = scan; sampled only in IDLE.
- sel  in  SEL_W  select for direct mode.
- start  in  1  single-cycle request to begin a scan (mode=1, IDLE only).
- dwell  in  DWELL_W  each scan slot lasts dwell+1 cycles; latched at start.
- y  out  2^SEL_W  registered one-hot output, or all-zero.
- idx  out  SEL_W  index of the active scan slot; 0 outside a scan.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse when a scan completes.

## Operation
- Reset (rst=1 at an edge): state=IDLE, y=0, idx=0, busy=0, done=0, dwell counter=0, latched dwell=0. Reset overrides every other input, including mid-scan.
- IDLE, mode=0, en=1: y <= 1 << sel. The decode is fully general for any SEL_W.
- IDLE, mode=0, en=0: y <= 0.
- IDLE, mode=1 without start: y <= 0.
- IDLE, mode=1, start=1, en=1:
  - go to SCAN; latch dwell.
  - idx <= 0, y <= 1, counter <= 0, busy <= 1.
- IDLE, mode=1, start=1, en=0: start is ignored and not remembered.
- SCAN, en=1, counter < latched dwell: counter increments; y and idx hold.
- SCAN, en=1, counter == latched dwell, idx < 2^SEL_W-1: idx increments, y shifts left by one, counter <= 0.
- SCAN, en=1, counter == latched dwell, idx == 2^SEL_W-1:
  - go to IDLE.
  - y <= 0, idx <= 0, busy <= 0, done <= 1 for exactly one cycle.
- SCAN, en=0: y <= 0; idx, counter and state hold. When en returns to 1, y <= 1 << idx and counting resumes from the frozen value.
- Inputs ignored while in SCAN: start (no restart, no queueing), changes to mode, sel and dwell.
- Shift arithmetic: `1 << idx` never overflows, because idx is SEL_W bits.
- Counter width: the dwell counter is DWELL_W bits. Its maximum value is the latched dwell, so it never wraps.
- done is 0 in every cycle except the completion cycle.

## Timing
- Direct-mode latency is 1 cycle: sel sampled at edge k appears on y after edge k.
- Scan start latency is 1 cycle: start sampled at edge k gives y=1 and busy=1 after edge k.
- Each slot is dwell+1 enabled cycles. With dwell=0, y advances on every edge.
- A full scan takes 2^SEL_W × (dwell+1) enabled cycles from the start edge to the done edge.
- done asserts on the same edge that busy falls and y goes to 0.
- A new start is accepted no earlier than the edge after done; the IDLE cycle holding done is itself able to accept start.
- Cycles with en=0 extend the scan by the same number of cycles and emit no output pulse.
- rst asserted mid-scan gives reset values on the next edge and no done pulse.

## Test plan
- Direct decode, SEL_W=3, en=1, mode=0: sel=0..7 on successive cycles -> y=0x01,0x02,...,0x80, each one cycle later; en=0 -> y=0x00.
- Scan, SEL_W=2, dwell=2, pulse start:
  - y=0001 for 3 cycles, then 0010, 0100, 1000 (3 cycles each), with idx=0,1,2,3.
  - busy high for 12 cycles, then done=1 for 1 cycle with y=0000 and busy=0.
- Scan with dwell=0, SEL_W=3: y walks 0x01 through 0x80 on consecutive cycles; done pulses on the 9th edge after start.
- Pause and restart, SEL_W=2, dwell=3:
  - drop en for 4 cycles during slot idx=1 -> y=0000 and idx=1 throughout the gap; on resume, slot 1 finishes its remaining count; done arrives 4 cycles later than the unpaused run.
  - pulse start at the same time -> ignored, no restart.
- Mid-scan reset: assert rst during idx=2 -> next cycle y=0, idx=0, busy=0, done=0; a later start runs a full fresh scan.
- Back-to-back: start in the done cycle -> next cycle y=0001 and busy=1; mode toggled to 0 mid-scan has no effect until IDLE.

Source files
------------

// File: rtl/scan_decoder.sv
// scan_decoder: registered N-to-2^N one-hot decoder with direct decode and timed scan modes
module scan_decoder #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_mode,
    input  logic [SEL_W-1:0]      i_sel,
    input  logic                  i_start,
    input  logic [DWELL_W-1:0]    i_dwell,
    output logic [2**SEL_W-1:0]   o_y,
    output logic [SEL_W-1:0]      o_idx,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int                N    = 2 ** SEL_W;
    localparam logic [N-1:0]      ONE  = N'(1);
    localparam logic [SEL_W-1:0]  LAST = SEL_W'(N - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t               r_state, w_next;
    logic [N-1:0]         r_y, w_y;
    logic [SEL_W-1:0]     r_idx, w_idx;
    logic [DWELL_W-1:0]   r_cnt, w_cnt, r_dwell, w_dwell;
    logic                 r_busy, r_done, w_done;
    logic                 w_slot_end, w_last;

    assign w_slot_end = r_cnt == r_dwell;
    assign w_last     = r_idx == LAST;
    assign o_y        = r_y;
    assign o_idx      = r_idx;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // enter SCAN on an enabled start in scan mode; leave after the last slot's final count
    always_comb begin
        w_next = (r_state == IDLE) ? ((i_mode && i_start && i_en) ? SCAN : IDLE)
                                   : ((i_en && w_slot_end && w_last) ? IDLE : SCAN);
    end

    // next output/datapath values; en=0 in SCAN blanks y while idx and count hold
    always_comb begin
        w_y     = '0;
        w_idx   = '0;
        w_cnt   = r_cnt;
        w_dwell = r_dwell;
        w_done  = 1'b0;
        if (r_state == IDLE) begin
            if (!i_mode) begin
                w_y = i_en ? (ONE << i_sel) : '0;
            end else if (i_start && i_en) begin
                w_y     = ONE;
                w_cnt   = '0;
                w_dwell = i_dwell;
            end
        end else begin
            w_idx = r_idx;
            if (i_en) begin
                if (!w_slot_end) begin
                    w_cnt = r_cnt + DWELL_W'(1);
                    w_y   = ONE << r_idx;
                end else if (!w_last) begin
                    w_idx = r_idx + SEL_W'(1);
                    w_cnt = '0;
                    w_y   = ONE << w_idx;
                end else begin
                    w_idx  = '0;
                    w_cnt  = '0;
                    w_done = 1'b1;
                end
            end
        end
    end

    // registered outputs and scan datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_dwell <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_y     <= w_y;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_dwell <= w_dwell;
            r_busy  <= w_next == SCAN;
            r_done  <= w_done;
        end
    end
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed bench for two decoder widths against a slot-timing model
module tb_scan_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, mode = 1'b0, start = 1'b0;
    logic [2:0] sel = '0;
    logic [7:0] dwell = '0;

    logic [3:0] y2;
    logic [1:0] idx2;
    logic       busy2, done2;
    logic [7:0] y3;
    logic [2:0] idx3;
    logic       busy3, done3;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(2), .DWELL_W(8)) u2 (
        .clk(clk), .rst(rst), .i_en(en), .i_mode(mode), .i_sel(sel[1:0]),
        .i_start(start), .i_dwell(dwell),
        .o_y(y2), .o_idx(idx2), .o_busy(busy2), .o_done(done2)
    );

    scan_decoder #(.SEL_W(3), .DWELL_W(8)) u3 (
        .clk(clk), .rst(rst), .i_en(en), .i_mode(mode), .i_sel(sel),
        .i_start(start), .i_dwell(dwell),
        .o_y(y3), .o_idx(idx3), .o_busy(busy3), .o_done(done3)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a scan is described by the number of enabled cycles t elapsed since the
    // start edge; slot = t/(dwell+1), and the scan ends when t reaches outputs*(dwell+1).
    logic [7:0] m_y[2];
    int         m_idx[2], m_t[2], m_dw[2];
    bit         m_busy[2], m_done[2], m_scan[2];

    always @(posedge clk) begin : model
        int n, s;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            n = k ? 8 : 4;
            s = k ? int'(sel) : int'(sel[1:0]);
            m_done[k] = 1'b0;
            if (rst) begin
                m_scan[k] = 1'b0; m_y[k] = '0; m_idx[k] = 0; m_busy[k] = 1'b0; m_t[k] = 0; m_dw[k] = 0;
            end else if (!m_scan[k]) begin
                m_idx[k] = 0;
                m_busy[k] = 1'b0;
                if (!mode) m_y[k] = en ? 8'(1 << s) : 8'h00;
                else if (start && en) begin
                    m_scan[k] = 1'b1; m_dw[k] = int'(dwell); m_t[k] = 0; m_y[k] = 8'h01; m_busy[k] = 1'b1;
                end else m_y[k] = 8'h00;
            end else if (!en) begin
                m_y[k] = 8'h00;
            end else begin
                m_t[k]++;
                if (m_t[k] == n * (m_dw[k] + 1)) begin
                    m_scan[k] = 1'b0; m_y[k] = 8'h00; m_idx[k] = 0; m_busy[k] = 1'b0; m_done[k] = 1'b1;
                end else begin
                    m_idx[k] = m_t[k] / (m_dw[k] + 1);
                    m_y[k] = 8'(1 << m_idx[k]);
                end
            end
        end
    end

    // every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("y2",    int'(y2),    int'(m_y[0]));
            chk("idx2",  int'(idx2),  m_idx[0]);
            chk("busy2", int'(busy2), int'(m_busy[0]));
            chk("done2", int'(done2), int'(m_done[0]));
            chk("y3",    int'(y3),    int'(m_y[1]));
            chk("idx3",  int'(idx3),  m_idx[1]);
            chk("busy3", int'(busy3), int'(m_busy[1]));
            chk("done3", int'(done3), int'(m_done[1]));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        step(2);
        chk("rst_y2", int'(y2), 0);
        chk("rst_busy3", int'(busy3), 0);
        rst = 1'b0;

        // direct decode
        en = 1'b1; mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            step();
            chk("dir_y3", int'(y3), 1 << i);
        end
        en = 1'b0;
        step();
        chk("dir_off_y3", int'(y3), 0);

        // scan dwell=2 on the 4-output decoder: 12 busy cycles then done
        en = 1'b1; mode = 1'b1; dwell = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            chk("scan2_y", int'(y2), 1 << (c / 3));
            chk("scan2_idx", int'(idx2), c / 3);
            chk("scan2_busy", int'(busy2), 1);
            step();
        end
        chk("scan2_done", int'(done2), 1);
        chk("scan2_end_y", int'(y2), 0);
        chk("scan2_end_busy", int'(busy2), 0);
        step();
        chk("scan2_done_once", int'(done2), 0);
        step(30);

        // scan dwell=0 on the 8-output decoder
        dwell = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk("walk3_y", int'(y3), 1 << c);
            step();
        end
        chk("walk3_done", int'(done3), 1);
        chk("walk3_y0", int'(y3), 0);
        step(30);

        // pause during slot 1 with a stray start; done 4 cycles late
        dwell = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        step(5);
        chk("pause_pre_idx", int'(idx2), 1);
        en = 1'b0; start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("pause_y", int'(y2), 0);
            chk("pause_idx", int'(idx2), 1);
        end
        en = 1'b1; start = 1'b0;
        step();
        chk("resume_y", int'(y2), 4'b0010);
        step(9);
        chk("pause_not_yet", int'(done2), 0);
        step();
        chk("pause_done", int'(done2), 1);
        step(50);

        // mid-scan reset, then a fresh full scan
        dwell = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        step(4);
        chk("mid_idx", int'(idx2), 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_y", int'(y2), 0);
        chk("mrst_idx", int'(idx2), 0);
        chk("mrst_busy", int'(busy2), 0);
        chk("mrst_done", int'(done2), 0);
        step(3);
        start = 1'b1;
        step();
        start = 1'b0;
        step(7);
        chk("fresh_idx", int'(idx2), 3);
        step();
        chk("fresh_done", int'(done2), 1);
        step(30);

        // back-to-back start in the done cycle; mode change mid-scan ignored
        dwell = 8'd0; sel = 3'd2; start = 1'b1;
        step();
        start = 1'b0;
        step(4);
        chk("b2b_done", int'(done2), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_y", int'(y2), 4'b0001);
        chk("b2b_busy", int'(busy2), 1);
        mode = 1'b0;
        step();
        chk("b2b_mode_y", int'(y2), 4'b0010);
        step(3);
        chk("b2b_done2", int'(done2), 1);
        step();
        chk("b2b_direct_y", int'(y2), 4'b0100);
        step(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
